// File: rtl/clk_pkg.sv
// Shared hour-counter constants and display helpers, also used by the alarm block.
// Pure definitions: no state and no latency.
package clk_pkg;

  localparam int HR_W = 5;
  localparam logic [HR_W-1:0] HR_MAX_24 = 5'd23;
  localparam logic [HR_W-1:0] HR_HALF   = 5'd12;

  typedef logic [HR_W-1:0] hr24_t;

  // 12-h display folds 0 and 12 onto 12, so the shown range is 1..12.
  function automatic hr24_t hr_disp(input hr24_t h, input logic mode_24);
    hr24_t r;
    if (mode_24) begin
      r = h;
    end else begin
      r = (h >= HR_HALF) ? hr24_t'(h - HR_HALF) : h;
      if (r == '0) r = HR_HALF;
    end
    return r;
  endfunction

  function automatic logic [7:0] hr_bcd(input hr24_t v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(v - 5'd10);
    end else begin
      tens  = 4'd0;
      units = 4'(v);
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/clk_hr_decode.sv
// Combinational map of a 24-h hour to display hour (binary or BCD) and pm flag.
// Zero latency, no handshake.
module clk_hr_decode
  import clk_pkg::*;
#(
  parameter int BCD_OUT = 0,
  parameter int OUT_W   = 8
) (
  input  logic [HR_W-1:0]  h24,
  input  logic             mode_24,
  output logic [OUT_W-1:0] hr,
  output logic             pm
);

  hr24_t disp;

  assign disp = hr_disp(h24, mode_24);
  assign pm   = (h24 >= HR_HALF);

  generate
    if (BCD_OUT != 0) begin : g_bcd
      assign hr = OUT_W'(hr_bcd(disp));
    end else begin : g_bin
      assign hr = OUT_W'(disp);
    end
  endgenerate

endmodule

// File: rtl/clk_count_hr_cfg.sv
// Hour counter (0..23) with load, up/down count, wrap pulses and 12/24-h display.
// Outputs registered from next-state decode: no added latency, no backpressure.
module clk_count_hr_cfg
  import clk_pkg::*;
#(
  parameter int BCD_OUT = 0,
  parameter int RST_HR  = 0,
  parameter int OUT_W   = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             rst_counters,
  input  logic             count_up_hr,
  input  logic             count_dn_hr,
  input  logic             load_en,
  input  logic [HR_W-1:0]  load_val,
  input  logic             mode_24,
  output logic [OUT_W-1:0] hr,
  output logic             pm,
  output logic             day_carry,
  output logic             day_borrow,
  output logic             load_err
);

  generate
    if (RST_HR < 0 || RST_HR > 23 ||
        (BCD_OUT != 0 && OUT_W != 8) ||
        (BCD_OUT == 0 && OUT_W < 5)) begin : g_bad_param
      $error("clk_count_hr_cfg: illegal RST_HR/OUT_W/BCD_OUT combination");
    end
  endgenerate

  localparam hr24_t RST_H = hr24_t'(RST_HR);

  hr24_t            h24_q, h24_d;
  hr24_t            dec_in;
  logic [OUT_W-1:0] hr_q, hr_dec;
  logic             pm_q, pm_dec;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;

  always_comb begin
    h24_d    = h24_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (rst_counters) begin
      h24_d = RST_H;
    end else if (load_en) begin
      if (load_val <= HR_MAX_24) h24_d = load_val;
      else                       err_d = 1'b1;
    end else if (count_up_hr && !count_dn_hr) begin
      if (h24_q == HR_MAX_24) begin
        h24_d   = '0;
        carry_d = 1'b1;
      end else begin
        h24_d = h24_q + 1'b1;
      end
    end else if (count_dn_hr && !count_up_hr) begin
      if (h24_q == '0) begin
        h24_d    = HR_MAX_24;
        borrow_d = 1'b1;
      end else begin
        h24_d = h24_q - 1'b1;
      end
    end
  end

  // Decode the value being written this edge so hr/pm track h24 without lag.
  assign dec_in = rst ? RST_H : h24_d;

  clk_hr_decode #(
    .BCD_OUT (BCD_OUT),
    .OUT_W   (OUT_W)
  ) u_dec (
    .h24     (dec_in),
    .mode_24 (mode_24),
    .hr      (hr_dec),
    .pm      (pm_dec)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      h24_q    <= RST_H;
      hr_q     <= hr_dec;
      pm_q     <= pm_dec;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      h24_q    <= h24_d;
      hr_q     <= hr_dec;
      pm_q     <= pm_dec;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign hr         = hr_q;
  assign pm         = pm_q;
  assign day_carry  = carry_q;
  assign day_borrow = borrow_q;
  assign load_err   = err_q;

endmodule

// File: doc/clk_count_hr_cfg.md
CLK_COUNT_HR_CFG -- requirements
Module: clk_count_hr_cfg

Interface
REQ-001 Parameter BCD_OUT, default 0: 0 gives a binary hour output, 1 gives packed BCD (tens in [7:4], units in [3:0]).
REQ-002 Parameter RST_HR, default 0: internal 24-h value loaded on reset and on rst_counters; legal range 0..23.
REQ-003 Parameter OUT_W, default 8: width of hr; must be >=5 when BCD_OUT=0 and exactly 8 when BCD_OUT=1.
REQ-004 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rst_counters  in  1  synchronous clear to RST_HR; same effect as rst.
REQ-007 count_up_hr  in  1  advance one hour (carry from the minute counter).
REQ-008 count_dn_hr  in  1  retreat one hour (time-set).
REQ-009 load_en  in  1  load load_val this cycle.
REQ-010 load_val  in  5  hour to load, 24-h binary.
REQ-011 mode_24  in  1  1 selects 24-h display, 0 selects 12-h display.
REQ-012 hr  out  OUT_W  displayed hour, registered.
REQ-013 pm  out  1  1 when the internal hour is >=12, registered.
REQ-014 day_carry  out  1  one-cycle pulse on the up-wrap 23->0.
REQ-015 day_borrow  out  1  one-cycle pulse on the down-wrap 0->23.
REQ-016 load_err  out  1  one-cycle pulse when load_en is set and load_val>23.

Function
REQ-017 The block SHALL hold one 5-bit internal hour h24 in the range 0..23; every output derives from h24 and mode_24.
REQ-018 Per-edge priority SHALL be: rst, then rst_counters, then load_en, then count_up_hr/count_dn_hr.
REQ-019 On load_en with load_val<=23, h24 SHALL become load_val; with load_val>23, h24 SHALL hold and load_err SHALL pulse; count inputs are ignored that cycle either way.
REQ-020 On count_up_hr alone, h24 SHALL step +1, and 23 SHALL wrap to 0 with day_carry=1 for that one cycle.
REQ-021 On count_dn_hr alone, h24 SHALL step -1, and 0 SHALL wrap to 23 with day_borrow=1 for that one cycle.
REQ-022 With count_up_hr and count_dn_hr both set, h24 SHALL hold and no pulse SHALL occur.
REQ-023 In 24-h display (mode_24=1), hr SHALL equal h24.
REQ-024 In 12-h display (mode_24=0), hr SHALL equal h24 mod 12, except that a result of 0 SHALL display as 12; the display range is 1..12.
REQ-025 pm SHALL be (h24>=12) in both modes.
REQ-026 When BCD_OUT=1, hr SHALL be BCD-encoded; for example h24=19 in 24-h mode gives 8'h19.
REQ-027 hr and pm SHALL reflect the h24 value produced at the same edge: zero added latency, with the decode computed from next-state.
REQ-028 A change of mode_24 SHALL leave h24 untouched; hr SHALL update at the next edge even with no count event.
REQ-029 day_carry, day_borrow and load_err SHALL each be high for exactly one cycle per event and low otherwise.
REQ-030 Unused upper bits of hr (when OUT_W>5 in binary mode) SHALL be 0.

Reset
REQ-031 When rst=1 at an edge: h24=RST_HR; hr and pm decode RST_HR under the current mode_24; day_carry, day_borrow and load_err are 0.
REQ-032 A reset asserted mid-operation SHALL override any simultaneous load or count, and no pulse SHALL be emitted in that cycle.
REQ-033 With the defaults, the reset-state output SHALL be hr=12, pm=0 in 12-h mode, and hr=0 in 24-h mode.

Structure
REQ-034 The shared package clk_pkg SHALL hold HR_MAX_24=23, HR_HALF=12 and HR_W=5.
REQ-035 A combinational sub-module clk_hr_decode SHALL map (h24, mode_24) to display hour, pm and optional BCD; it is reused by the alarm block.
REQ-036 The synthesis check SHALL reject illegal parameter combinations (RST_HR>23; OUT_W outside the ranges in REQ-003).

Verification
REQ-037 12-h rollover: reset, mode_24=0, then 24 pulses of count_up_hr -> hr sequence 12,1..11,12,1..11,12; pm rises at the 12th pulse; day_carry pulses once, on the 24th pulse.
REQ-038 Down-wrap: load 0, then one count_dn_hr -> h24=23, hr=11 (12-h) or 23 (24-h), day_borrow pulses once.
REQ-039 Load error: load_val=24 with load_en=1 while h24=7 -> load_err pulses, hr unchanged.
REQ-040 Simultaneous events: load_en with count_up_hr -> load wins; count_up_hr with count_dn_hr -> hold, no pulses; rst with load_en -> h24=RST_HR, no pulses.
REQ-041 BCD and mode switch: BCD_OUT=1, load 21, mode_24=1 -> hr=8'h21; toggle to mode_24=0 -> next edge hr=8'h09, pm=1.
REQ-042 rst_counters asserted mid-count at h24=15 -> next edge h24=RST_HR, no day_carry.
